// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared state type and stream constants for the MAC transmit arbiter
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam logic [7:0] ABORT_TKEEP = 8'h01;
  localparam int         AXIS_DW     = 64;

endpackage

// File: rtl/eth_tx_arb.sv
// rtl/eth_tx_arb.sv - two-port packet-granular round-robin arbiter onto the 10G MAC tx stream
// A frame whose source stalls too long is closed with a tuser-marked beat and the remainder discarded.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 256,
  parameter int CNT_W        = 32
) (
  input  logic                 clk156,
  input  logic                 sys_rst,
  input  logic                 s0_axis_tvalid,
  output logic                 s0_axis_tready,
  input  logic [AXIS_DW-1:0]   s0_axis_tdata,
  input  logic [AXIS_DW/8-1:0] s0_axis_tkeep,
  input  logic                 s0_axis_tlast,
  input  logic                 s0_axis_tuser,
  input  logic                 s1_axis_tvalid,
  output logic                 s1_axis_tready,
  input  logic [AXIS_DW-1:0]   s1_axis_tdata,
  input  logic [AXIS_DW/8-1:0] s1_axis_tkeep,
  input  logic                 s1_axis_tlast,
  input  logic                 s1_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [AXIS_DW-1:0]   m_axis_tdata,
  output logic [AXIS_DW/8-1:0] m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 grant,
  output logic                 busy,
  output logic [CNT_W-1:0]     frames0,
  output logic [CNT_W-1:0]     frames1,
  output logic [CNT_W-1:0]     aborts
);

  localparam int            IW        = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  arb_state_t           state, state_nxt;
  logic                 last_grant;
  logic                 pick;
  logic [IW-1:0]        idle_cnt;
  logic                 sel_tvalid, sel_tlast, sel_tuser;
  logic [AXIS_DW-1:0]   sel_tdata;
  logic [AXIS_DW/8-1:0] sel_tkeep;
  logic                 frame_done, abort_done, drain_done;

  assign sel_tvalid = grant ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_tdata  = grant ? s1_axis_tdata  : s0_axis_tdata;
  assign sel_tkeep  = grant ? s1_axis_tkeep  : s0_axis_tkeep;
  assign sel_tlast  = grant ? s1_axis_tlast  : s0_axis_tlast;
  assign sel_tuser  = grant ? s1_axis_tuser  : s0_axis_tuser;

  // Contention alternates away from the last winner; a lone requester wins outright.
  assign pick = (s0_axis_tvalid && s1_axis_tvalid) ? ~last_grant : s1_axis_tvalid;
  assign busy = (state != IDLE);

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    frame_done     = 1'b0;
    abort_done     = 1'b0;
    drain_done     = 1'b0;
    case (state)
      IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) state_nxt = SEND;
      end
      SEND: begin
        m_axis_tvalid  = sel_tvalid;
        m_axis_tdata   = sel_tdata;
        m_axis_tkeep   = sel_tkeep;
        m_axis_tlast   = sel_tlast;
        m_axis_tuser   = sel_tuser;
        s0_axis_tready = !grant && m_axis_tready;
        s1_axis_tready = grant && m_axis_tready;
        if (sel_tvalid && m_axis_tready && sel_tlast) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else if (!sel_tvalid && idle_cnt == IDLE_LAST) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        m_axis_tkeep  = ABORT_TKEEP;
        if (m_axis_tready) begin
          abort_done = 1'b1;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        s0_axis_tready = !grant;
        s1_axis_tready = grant;
        if (sel_tvalid && sel_tlast) begin
          drain_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Idle count only runs while a granted frame is open; backpressure never advances it.
  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      idle_cnt   <= '0;
      frames0    <= '0;
      frames1    <= '0;
      aborts     <= '0;
    end else begin
      if (state == IDLE && (s0_axis_tvalid || s1_axis_tvalid)) grant <= pick;
      if (state != SEND || sel_tvalid) idle_cnt <= '0;
      else                             idle_cnt <= idle_cnt + IW'(1);
      if (frame_done || drain_done) last_grant <= grant;
      if (frame_done && !grant) frames0 <= frames0 + CNT_W'(1);
      if (frame_done && grant)  frames1 <= frames1 + CNT_W'(1);
      if (abort_done)           aborts  <= aborts + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb/tb_eth_tx_arb.sv - self-checking bench for eth_tx_arb
// Frame-level model predicts the MAC beat stream and counters; directed literals pin latencies.
module tb_eth_tx_arb;

  localparam int TO = 4;
  localparam int CW = 4;

  typedef struct {
    bit          gap;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } ent_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    int          kind;
  } exp_t;

  logic          clk156 = 1'b0;
  logic          sys_rst = 1'b1;
  logic          s0_tvalid = 1'b0, s0_tready, s0_tlast = 1'b0, s0_tuser = 1'b0;
  logic [63:0]   s0_tdata = '0;
  logic [7:0]    s0_tkeep = '0;
  logic          s1_tvalid = 1'b0, s1_tready, s1_tlast = 1'b0, s1_tuser = 1'b0;
  logic [63:0]   s1_tdata = '0;
  logic [7:0]    s1_tkeep = '0;
  logic          m_tvalid, m_tready = 1'b1, m_tlast, m_tuser;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic          grant, busy;
  logic [CW-1:0] frames0, frames1, aborts;

  ent_t          src0[$], src1[$], fbuf[$];
  exp_t          exp_q[$];
  logic [CW-1:0] mf0 = '0, mf1 = '0, mab = '0;
  logic          mr_next = 1'b1;
  logic          prev_stall = 1'b0;
  logic [63:0]   pd = '0;
  logic [7:0]    pk = '0;
  logic          pl = 1'b0;
  int            checks = 0, errors = 0;

  always #5 clk156 = ~clk156;

  eth_tx_arb #(.IDLE_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk156(clk156), .sys_rst(sys_rst),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready), .s0_axis_tdata(s0_tdata),
    .s0_axis_tkeep(s0_tkeep), .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready), .s1_axis_tdata(s1_tdata),
    .s1_axis_tkeep(s1_tkeep), .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .grant(grant), .busy(busy), .frames0(frames0), .frames1(frames1), .aborts(aborts)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: cycle bound expired", name);
  endtask

  task automatic build_frame(input int port, input int id, input int nbeats,
                             input int gap_after, input int gap_len, input bit user);
    ent_t x;
    fbuf.delete();
    for (int b = 0; b < nbeats; b++) begin
      x.gap  = 1'b0;
      x.data = {16'hF00D, 8'(port), 8'(id), 16'(b), 16'($urandom)};
      x.last = (b == nbeats - 1);
      x.keep = x.last ? 8'h3F : 8'hFF;
      x.user = user;
      fbuf.push_back(x);
      if (b == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          x.gap = 1'b1;
          fbuf.push_back(x);
        end
      end
    end
  endtask

  task automatic src_push(input int port);
    foreach (fbuf[i]) begin
      if (port == 0) src0.push_back(fbuf[i]);
      else           src1.push_back(fbuf[i]);
    end
  endtask

  // A source idle run reaching TO inside a frame turns the rest of it into one abort beat.
  task automatic model_expect(input int port);
    exp_t e;
    int   run;
    bit   cut;
    run = 0;
    cut = 1'b0;
    foreach (fbuf[i]) begin
      if (!cut) begin
        if (fbuf[i].gap) begin
          run++;
          if (run >= TO) begin
            e.data = '0; e.keep = 8'h01; e.last = 1'b1; e.user = 1'b1; e.kind = 3;
            exp_q.push_back(e);
            cut = 1'b1;
          end
        end else begin
          run    = 0;
          e.data = fbuf[i].data;
          e.keep = fbuf[i].keep;
          e.last = fbuf[i].last;
          e.user = fbuf[i].user;
          e.kind = fbuf[i].last ? port + 1 : 0;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic drive();
    if (src0.size() == 0 || src0[0].gap) s0_tvalid = 1'b0;
    else begin
      s0_tvalid = 1'b1; s0_tdata = src0[0].data; s0_tkeep = src0[0].keep;
      s0_tlast = src0[0].last; s0_tuser = src0[0].user;
    end
    if (src1.size() == 0 || src1[0].gap) s1_tvalid = 1'b0;
    else begin
      s1_tvalid = 1'b1; s1_tdata = src1[0].data; s1_tkeep = src1[0].keep;
      s1_tlast = src1[0].last; s1_tuser = src1[0].user;
    end
  endtask

  task automatic sample_pop();
    ent_t tmp;
    if (src0.size() > 0 && (src0[0].gap || (s0_tvalid && s0_tready))) tmp = src0.pop_front();
    if (src1.size() > 0 && (src1[0].gap || (s1_tvalid && s1_tready))) tmp = src1.pop_front();
  endtask

  task automatic compare();
    exp_t e;
    if (sys_rst) begin
      exp_q.delete();
      mf0 = '0; mf1 = '0; mab = '0;
      prev_stall = 1'b0;
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end else begin
      chk("frames0", 64'(frames0), 64'(mf0));
      chk("frames1", 64'(frames1), 64'(mf1));
      chk("aborts", 64'(aborts), 64'(mab));
      if (prev_stall) begin
        chk("hold_tvalid", 64'(m_tvalid), 64'd1);
        chk("hold_tdata", m_tdata, pd);
        chk("hold_tkeep", 64'(m_tkeep), 64'(pk));
        chk("hold_tlast", 64'(m_tlast), 64'(pl));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got tdata %0h want no beat", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_tdata", m_tdata, e.data);
          chk("beat_tkeep", 64'(m_tkeep), 64'(e.keep));
          chk("beat_tlast", 64'(m_tlast), 64'(e.last));
          chk("beat_tuser", 64'(m_tuser), 64'(e.user));
          if (e.kind == 1) mf0 = mf0 + 1'b1;
          if (e.kind == 2) mf1 = mf1 + 1'b1;
          if (e.kind == 3) mab = mab + 1'b1;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      pd = m_tdata; pk = m_tkeep; pl = m_tlast;
    end
  endtask

  task automatic step();
    @(posedge clk156);
    #1;
    m_tready = mr_next;
    drive();
    @(negedge clk156);
    compare();
    sample_pop();
  endtask

  task automatic wait_hs(input string name, input bit need_last);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_tvalid && m_tready && (m_tlast || !need_last)) && n < 60);
    if (!(m_tvalid && m_tready && (m_tlast || !need_last))) fail_now(name);
  endtask

  task automatic run_idle(input string name);
    int n;
    n = 0;
    while (!(src0.size() == 0 && src1.size() == 0 && exp_q.size() == 0 && !busy) && n < 200) begin
      step();
      n++;
    end
    if (!(src0.size() == 0 && src1.size() == 0 && exp_q.size() == 0 && !busy)) fail_now(name);
  endtask

  // Reset is raised mid-cycle so the checks below observe its asynchronous effect.
  task automatic do_reset();
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_async_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_async_busy", 64'(busy), 64'd0);
    chk("rst_async_grant", 64'(grant), 64'd0);
    chk("rst_async_s0_tready", 64'(s0_tready), 64'd0);
    chk("rst_async_s1_tready", 64'(s1_tready), 64'd0);
    chk("rst_async_tdata", m_tdata, 64'd0);
    chk("rst_async_tkeep", 64'(m_tkeep), 64'd0);
    chk("rst_async_tlast_tuser", {62'd0, m_tlast, m_tuser}, 64'd0);
    chk("rst_async_counters", {52'd0, frames0, frames1, aborts}, 64'd0);
    src0.delete();
    src1.delete();
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    step();
    step();
    #2 sys_rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single source, 3-beat frame: one cycle of arbitration latency.
    build_frame(0, 1, 3, -1, 0, 1'b0); src_push(0); model_expect(0);
    step();
    chk("lat_idle_tvalid", 64'(m_tvalid), 64'd0);
    step();
    chk("lat_send_tvalid", 64'(m_tvalid), 64'd1);
    chk("lat_send_grant", 64'(grant), 64'd0);
    chk("lat_send_busy", 64'(busy), 64'd1);
    run_idle("t1_idle");
    chk("t1_frames0", 64'(frames0), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);

    // Contention from reset: s0, s1, s0, s1 with a single bubble between frames.
    do_reset();
    build_frame(0, 2, 2, -1, 0, 1'b0); src_push(0); model_expect(0);
    build_frame(1, 3, 2, -1, 0, 1'b1); src_push(1); model_expect(1);
    build_frame(0, 4, 2, -1, 0, 1'b0); src_push(0); model_expect(0);
    build_frame(1, 5, 2, -1, 0, 1'b0); src_push(1); model_expect(1);
    wait_hs("t2_first_tlast", 1'b1);
    step();
    chk("t2_bubble_tvalid", 64'(m_tvalid), 64'd0);
    chk("t2_bubble_busy", 64'(busy), 64'd0);
    step();
    chk("t2_b2b_tvalid", 64'(m_tvalid), 64'd1);
    chk("t2_b2b_grant", 64'(grant), 64'd1);
    run_idle("t2_idle");
    chk("t2_frames0", 64'(frames0), 64'd2);
    chk("t2_frames1", 64'(frames1), 64'd2);

    // Idle gap of TO-1 survives; a gap of TO aborts and the remainder is drained.
    build_frame(0, 6, 3, 0, TO - 1, 1'b0); src_push(0); model_expect(0);
    run_idle("t3_short_gap");
    chk("t3_no_abort", 64'(aborts), 64'd0);
    chk("t3_frames0", 64'(frames0), 64'd3);
    build_frame(1, 7, 3, 0, TO, 1'b0); src_push(1); model_expect(1);
    wait_hs("t3_first_beat", 1'b0);
    for (int i = 0; i < TO; i++) begin
      step();
      chk("t3_gap_tvalid", 64'(m_tvalid), 64'd0);
    end
    step();
    chk("t3_abort_beat", {m_tdata[55:0], m_tkeep}, 64'h01);
    chk("t3_abort_flags", {61'd0, m_tvalid, m_tlast, m_tuser}, 64'h7);
    run_idle("t3_drain");
    chk("t3_aborts", 64'(aborts), 64'd1);
    chk("t3_frames1", 64'(frames1), 64'd2);

    // Long backpressure mid-frame never aborts.
    build_frame(0, 8, 3, -1, 0, 1'b0); src_push(0); model_expect(0);
    wait_hs("t4_first_beat", 1'b0);
    mr_next = 1'b0;
    for (int i = 0; i < 1000; i++) step();
    chk("t4_stall_tvalid", 64'(m_tvalid), 64'd1);
    chk("t4_stall_busy", 64'(busy), 64'd1);
    chk("t4_stall_aborts", 64'(aborts), 64'd1);
    mr_next = 1'b1;
    run_idle("t4_idle");
    chk("t4_frames0", 64'(frames0), 64'd4);

    // Single-beat frames, counter wrap, then reset mid-frame.
    do_reset();
    build_frame(0, 9, 1, -1, 0, 1'b0); src_push(0); model_expect(0);
    run_idle("t5_single");
    chk("t5_single_frames0", 64'(frames0), 64'd1);
    for (int i = 0; i < 15; i++) begin
      build_frame(0, 10 + i, 1, -1, 0, 1'b0); src_push(0); model_expect(0);
    end
    run_idle("t5_wrap");
    chk("t5_wrap_frames0", 64'(frames0), 64'd0);
    build_frame(1, 40, 3, -1, 0, 1'b0); src_push(1); model_expect(1);
    wait_hs("t5_midframe", 1'b0);
    do_reset();
    build_frame(1, 41, 2, -1, 0, 1'b0); src_push(1);
    build_frame(0, 42, 2, -1, 0, 1'b0); src_push(0); model_expect(0);
    build_frame(1, 41, 2, -1, 0, 1'b0);
    fbuf = src1;
    model_expect(1);
    step();
    chk("t5_post_idle", 64'(m_tvalid), 64'd0);
    step();
    chk("t5_post_tvalid", 64'(m_tvalid), 64'd1);
    chk("t5_post_grant", 64'(grant), 64'd0);
    run_idle("t5_post");
    chk("t5_post_frames0", 64'(frames0), 64'd1);
    chk("t5_post_frames1", 64'(frames1), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
